// File: rtl/seq_mag_comparator.sv
// Iterative magnitude comparator: walks the operands DIGIT bits per cycle from
// the MSB digit and stops at the first differing digit, reporting eq/gt/lt.
module seq_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] num0,
  input  logic [WIDTH-1:0] num1,
  output logic             ready,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             smode_reg;
  logic [IW-1:0]    idx;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [DIGIT-1:0] dig_a, dig_b;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    a_sh  = a_reg >> (int'(idx) * DIGIT);
    b_sh  = b_reg >> (int'(idx) * DIGIT);
    dig_a = a_sh[DIGIT-1:0];
    dig_b = b_sh[DIGIT-1:0];
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    if (smode_reg && idx == LAST) begin
      dig_a[DIGIT-1] = ~dig_a[DIGIT-1];
      dig_b[DIGIT-1] = ~dig_b[DIGIT-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs as they were before the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      ready     <= 1'b1;
      done      <= 1'b0;
      eq        <= 1'b0;
      gt        <= 1'b0;
      lt        <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      smode_reg <= 1'b0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg     <= num0;
            b_reg     <= num1;
            smode_reg <= signed_mode;
            idx       <= LAST;
            eq        <= 1'b0;
            gt        <= 1'b0;
            lt        <= 1'b0;
            ready     <= 1'b0;
            state     <= CMP;
          end
        end
        CMP: begin
          if (dig_a > dig_b) begin
            gt    <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (dig_a < dig_b) begin
            lt    <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else if (idx == '0) begin
            eq    <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
// Directed bench for seq_mag_comparator: a 16-bit/2-bit-digit instance and an
// 8-bit/1-bit-digit instance, with hand-computed latencies and flags.
module tb_seq_mag_comparator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        start16 = 1'b0, sm16 = 1'b0;
  logic [15:0] n0_16 = '0, n1_16 = '0;
  logic        ready16, done16, eq16, gt16, lt16;

  logic        start8 = 1'b0, sm8 = 1'b0;
  logic [7:0]  n0_8 = '0, n1_8 = '0;
  logic        ready8, done8, eq8, gt8, lt8;

  seq_mag_comparator #(.WIDTH(16), .DIGIT(2)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start16), .signed_mode(sm16),
    .num0(n0_16), .num1(n1_16), .ready(ready16), .done(done16),
    .eq(eq16), .gt(gt16), .lt(lt16)
  );

  seq_mag_comparator #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .signed_mode(sm8),
    .num0(n0_8), .num1(n1_8), .ready(ready8), .done(done8),
    .eq(eq8), .gt(gt8), .lt(lt8)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // {ready, done, eq, gt, lt} of the selected instance
  function automatic logic [4:0] outs(input int sel);
    if (sel == 0) return {ready16, done16, eq16, gt16, lt16};
    else          return {ready8, done8, eq8, gt8, lt8};
  endfunction

  task automatic drive(input int sel, input logic st, input logic [15:0] a,
                       input logic [15:0] b, input logic sm);
    if (sel == 0) begin
      start16 = st; n0_16 = a; n1_16 = b; sm16 = sm;
    end else begin
      start8 = st; n0_8 = a[7:0]; n1_8 = b[7:0]; sm8 = sm;
    end
  endtask

  // Issues one compare and checks done cycle, flags ({eq,gt,lt}), ready low
  // through the done cycle and ready back high afterwards.
  task automatic run(input string tag, input int sel, input logic [15:0] a,
                     input logic [15:0] b, input logic sm, input int exp_cyc,
                     input logic [2:0] exp_flags);
    int cyc, got, rdy_hi;
    logic [4:0] o;
    @(negedge clk);
    drive(sel, 1'b1, a, b, sm);
    @(negedge clk);
    drive(sel, 1'b0, 16'h0, 16'h0, 1'b0);
    cyc = 1; got = 0; rdy_hi = 0;
    o = outs(sel);
    while (cyc <= 40) begin
      o = outs(sel);
      if (o[4]) rdy_hi++;
      if (o[3]) begin
        got = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, " done cycle"}, got, exp_cyc);
    check({tag, " flags"}, {29'h0, o[2:0]}, {29'h0, exp_flags});
    check({tag, " ready low while busy"}, rdy_hi, 0);
    @(negedge clk);
    o = outs(sel);
    check({tag, " ready back, done gone"}, {30'h0, o[4:3]}, 32'h2);
  endtask

  initial begin
    int dones, first, changes;
    logic [4:0] o, prev;

    // Reset
    repeat (2) @(negedge clk);
    check("reset 16", {27'h0, outs(0)}, 32'h10);
    check("reset 8", {27'h0, outs(1)}, 32'h10);
    reset_n = 1'b1;

    // 1: equal operands, full walk
    run("eq A5A5", 0, 16'hA5A5, 16'hA5A5, 1'b0, 9, 3'b100);

    // 2: MSB digit decides, unsigned then signed
    run("8000>7FFF u", 0, 16'h8000, 16'h7FFF, 1'b0, 2, 3'b010);
    run("8000<7FFF s", 0, 16'h8000, 16'h7FFF, 1'b1, 2, 3'b001);

    // 3: LSB digit decides, then flags hold while idle
    run("1234<1235", 0, 16'h1234, 16'h1235, 1'b0, 9, 3'b001);
    changes = 0;
    prev = outs(0);
    repeat (5) begin
      @(negedge clk);
      o = outs(0);
      if (o !== prev) changes++;
    end
    check("flags hold idle", {27'h0, o}, 32'h11);
    check("no change idle", changes, 0);

    // 4: start while busy is ignored
    @(negedge clk);
    drive(0, 1'b1, 16'h00FF, 16'h0000, 1'b0);
    @(negedge clk);
    drive(0, 1'b1, 16'h0000, 16'hFFFF, 1'b0);
    dones = 0; first = 0;
    for (int c = 1; c <= 14; c++) begin
      if (c == 2) drive(0, 1'b0, 16'h0000, 16'hFFFF, 1'b0);
      if (done16) begin
        dones++;
        if (first == 0) begin
          first = c;
          check("busy start flags", {29'h0, eq16, gt16, lt16}, 32'h2);
        end
      end
      @(negedge clk);
    end
    check("busy start done cycle", first, 6);
    check("busy start done count", dones, 1);
    check("busy start result held", {29'h0, eq16, gt16, lt16}, 32'h2);
    run("0000<FFFF", 0, 16'h0000, 16'hFFFF, 1'b0, 2, 3'b001);

    // 5: reset mid-compare aborts
    @(negedge clk);
    drive(0, 1'b1, 16'h3C3C, 16'h3C3C, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 16'h0, 16'h0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("abort state", {27'h0, outs(0)}, 32'h10);
    dones = 0;
    repeat (12) begin
      @(negedge clk);
      if (done16) dones++;
    end
    check("abort no done", dones, 0);

    // 6: one-bit digits
    run("FF>FE s", 1, 16'h00FF, 16'h00FE, 1'b1, 9, 3'b010);
    run("7F<80 u", 1, 16'h007F, 16'h0080, 1'b0, 2, 3'b001);
    run("7F>80 s", 1, 16'h007F, 16'h0080, 1'b1, 2, 3'b010);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
